// File: rtl/pio_pkg.sv
// Shared constants, state encoding and helpers for the PIO completion TX path.
package pio_pkg;

    localparam logic [1:0] FMT_CPLD = 2'b10;
    localparam logic [1:0] FMT_CPL  = 2'b00;

    localparam logic [4:0] TYPE_CPL = 5'b01010;

    typedef logic [1:0] pio_state_t;

    localparam pio_state_t ST_IDLE    = 2'd0;
    localparam pio_state_t ST_RD_WAIT = 2'd1;
    localparam pio_state_t ST_BEAT0   = 2'd2;
    localparam pio_state_t ST_BEAT1   = 2'd3;

    localparam logic [7:0] KEEP_ALL   = 8'hFF;
    localparam logic [7:0] KEEP_LO_DW = 8'h0F;

    // Register space is little-endian; the TLP payload carries bytes in wire order.
    function automatic logic [31:0] byteswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/pio_cpl_bc_calc.sv
// Byte count and lower address of a single-DW completion, from first-DW byte enables.
module pio_cpl_bc_calc (
    input  logic [3:0]  be,
    input  logic [6:0]  addr,
    output logic [11:0] byte_count,
    output logic [6:0]  lower_addr
);

    logic [1:0] low2;
    logic       unused_addr_lsb;

    // The low two address bits come from the byte enables, never from the request address.
    assign unused_addr_lsb = ^addr[1:0];

    always_comb begin
        byte_count = 12'd1;
        casez (be)
            4'b1??1:                   byte_count = 12'd4;
            4'b01?1, 4'b1?10:          byte_count = 12'd3;
            4'b0011, 4'b0110, 4'b1100: byte_count = 12'd2;
            default:                   byte_count = 12'd1;
        endcase
    end

    always_comb begin
        low2 = 2'b00;
        if (be[0]) begin
            low2 = 2'b00;
        end else if (be[1]) begin
            low2 = 2'b01;
        end else if (be[2]) begin
            low2 = 2'b10;
        end else if (be[3]) begin
            low2 = 2'b11;
        end
    end

    assign lower_addr = {addr[6:2], low2};

endmodule

// File: rtl/pio_tx_cpl_engine.sv
// Builds a 3-DW Cpl/CplD for one PIO read request and sends it as two 64-bit AXI-Stream beats.
// Handshake: a beat transfers on a cycle where tvalid and tready are both high at the rising
// edge; while tready is low, tdata/tkeep/tlast hold and are never derived from tready.
module pio_tx_cpl_engine
    import pio_pkg::*;
#(
    parameter int TCQ = 1
) (
    input  logic        clk,
    input  logic        sys_rst_n,

    input  logic        req_compl,
    input  logic        req_compl_wd,
    input  logic [2:0]  req_tc,
    input  logic        req_td,
    input  logic        req_ep,
    input  logic [1:0]  req_attr,
    input  logic [9:0]  req_len,
    input  logic [15:0] req_rid,
    input  logic [7:0]  req_tag,
    input  logic [3:0]  req_be,
    input  logic [13:0] req_addr,
    input  logic [1:0]  req_bar,
    input  logic [15:0] completer_id,

    output logic [13:0] rd_addr,
    output logic [3:0]  rd_be,
    input  logic [31:0] rd_data,

    output logic [63:0] s_axis_tx_tdata,
    output logic [7:0]  s_axis_tx_tkeep,
    output logic        s_axis_tx_tlast,
    output logic        s_axis_tx_tvalid,
    input  logic        s_axis_tx_tready,
    output logic [3:0]  s_axis_tx_tuser,

    output logic        compl_done,
    output logic        compl_busy,
    output logic [1:0]  dbg_state
);

    // Registers are zero-delay; TCQ is kept only for drop-in compatibility.
    localparam int unused_tcq = TCQ;

    pio_state_t state_q, state_d;

    logic        wd_q;
    logic [2:0]  tc_q;
    logic        td_q;
    logic        ep_q;
    logic [1:0]  attr_q;
    logic [9:0]  len_q;
    logic [15:0] rid_q;
    logic [7:0]  tag_q;
    logic [3:0]  be_q;
    logic [13:0] addr_q;
    logic [1:0]  bar_q;
    logic [31:0] rd_data_q;
    logic        done_q, done_d;

    logic        capture;
    logic        handshake;
    logic [11:0] byte_count;
    logic [6:0]  lower_addr;
    logic [31:0] dw0, dw1, dw2;

    assign capture   = (state_q == ST_IDLE) && req_compl;
    assign handshake = s_axis_tx_tvalid && s_axis_tx_tready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (req_compl) state_d = ST_RD_WAIT;
            ST_RD_WAIT: state_d = ST_BEAT0;
            ST_BEAT0:   if (handshake) state_d = ST_BEAT1;
            ST_BEAT1:   if (handshake) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign done_d = (state_q == ST_BEAT1) && handshake;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wd_q   <= 1'b0;
            tc_q   <= 3'd0;
            td_q   <= 1'b0;
            ep_q   <= 1'b0;
            attr_q <= 2'd0;
            len_q  <= 10'd0;
            rid_q  <= 16'd0;
            tag_q  <= 8'd0;
            be_q   <= 4'd0;
            addr_q <= 14'd0;
            bar_q  <= 2'd0;
        end else if (capture) begin
            wd_q   <= req_compl_wd;
            tc_q   <= req_tc;
            td_q   <= req_td;
            ep_q   <= req_ep;
            attr_q <= req_attr;
            len_q  <= req_len;
            rid_q  <= req_rid;
            tag_q  <= req_tag;
            be_q   <= req_be;
            addr_q <= req_addr;
            bar_q  <= req_bar;
        end
    end

    // The read port settles during RD_WAIT; the word is frozen here for BEAT1.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_data_q <= 32'd0;
        end else if (state_q == ST_RD_WAIT) begin
            rd_data_q <= rd_data;
        end
    end

    pio_cpl_bc_calc u_bc_calc (
        .be         (be_q),
        .addr       (addr_q[6:0]),
        .byte_count (byte_count),
        .lower_addr (lower_addr)
    );

    assign dw0 = {1'b0, (wd_q ? FMT_CPLD : FMT_CPL), TYPE_CPL, 1'b0, tc_q, 4'b0000,
                  td_q, ep_q, attr_q, 2'b00, len_q};
    assign dw1 = {completer_id, 3'b000, 1'b0, byte_count};
    assign dw2 = {rid_q, tag_q, 1'b0, lower_addr};

    always_comb begin
        s_axis_tx_tdata  = 64'd0;
        s_axis_tx_tkeep  = 8'd0;
        s_axis_tx_tlast  = 1'b0;
        s_axis_tx_tvalid = 1'b0;
        case (state_q)
            ST_BEAT0: begin
                s_axis_tx_tdata  = {dw1, dw0};
                s_axis_tx_tkeep  = KEEP_ALL;
                s_axis_tx_tvalid = 1'b1;
            end
            ST_BEAT1: begin
                if (wd_q) begin
                    s_axis_tx_tdata = {byteswap32(rd_data_q), dw2};
                    s_axis_tx_tkeep = KEEP_ALL;
                end else begin
                    s_axis_tx_tdata = {32'd0, dw2};
                    s_axis_tx_tkeep = KEEP_LO_DW;
                end
                s_axis_tx_tlast  = 1'b1;
                s_axis_tx_tvalid = 1'b1;
            end
            default: ;
        endcase
    end

    assign compl_busy      = (state_q != ST_IDLE);
    assign rd_addr         = compl_busy ? {bar_q, addr_q[13:2]} : 14'd0;
    assign rd_be           = compl_busy ? be_q : 4'd0;
    assign compl_done      = done_q;
    assign s_axis_tx_tuser = 4'b0000;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_pio_tx_cpl_engine.sv
// Scoreboard bench for pio_tx_cpl_engine: directed requests push expected beats,
// a negedge monitor pops and compares every handshake and checks compl_done timing.
module tb_pio_tx_cpl_engine;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        req_compl, req_compl_wd, req_td, req_ep;
  logic [2:0]  req_tc;
  logic [1:0]  req_attr, req_bar;
  logic [9:0]  req_len;
  logic [15:0] req_rid, completer_id;
  logic [7:0]  req_tag;
  logic [3:0]  req_be;
  logic [13:0] req_addr;
  logic [13:0] rd_addr;
  logic [3:0]  rd_be;
  logic [31:0] rd_data;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast, tvalid, tready;
  logic [3:0]  tuser;
  logic        compl_done, compl_busy;
  logic [1:0]  dbg_state;

  logic [13:0] mem_addr;
  logic [31:0] mem_word;

  int n_tests = 0;
  int n_fail = 0;
  int exp_done = 0;
  int done_seen = 0;
  int hs_count = 0;
  logic hs_last_prev = 1'b0;
  logic [72:0] exp_q[$];

  always #5 clk = ~clk;

  // Register space model: only the expected address returns the test word.
  assign rd_data = (rd_addr == mem_addr) ? mem_word : 32'hDEADBEEF;

  pio_tx_cpl_engine #(.TCQ(1)) dut (
    .clk              (clk),
    .sys_rst_n        (sys_rst_n),
    .req_compl        (req_compl),
    .req_compl_wd     (req_compl_wd),
    .req_tc           (req_tc),
    .req_td           (req_td),
    .req_ep           (req_ep),
    .req_attr         (req_attr),
    .req_len          (req_len),
    .req_rid          (req_rid),
    .req_tag          (req_tag),
    .req_be           (req_be),
    .req_addr         (req_addr),
    .req_bar          (req_bar),
    .completer_id     (completer_id),
    .rd_addr          (rd_addr),
    .rd_be            (rd_be),
    .rd_data          (rd_data),
    .s_axis_tx_tdata  (tdata),
    .s_axis_tx_tkeep  (tkeep),
    .s_axis_tx_tlast  (tlast),
    .s_axis_tx_tvalid (tvalid),
    .s_axis_tx_tready (tready),
    .s_axis_tx_tuser  (tuser),
    .compl_done       (compl_done),
    .compl_busy       (compl_busy),
    .dbg_state        (dbg_state)
  );

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hand-written byte-enable tables.
  function automatic logic [11:0] exp_bc(input logic [3:0] be);
    case (be)
      4'h0: return 12'd1;  4'h1: return 12'd1;  4'h2: return 12'd1;  4'h3: return 12'd2;
      4'h4: return 12'd1;  4'h5: return 12'd3;  4'h6: return 12'd2;  4'h7: return 12'd3;
      4'h8: return 12'd1;  4'h9: return 12'd4;  4'hA: return 12'd3;  4'hB: return 12'd4;
      4'hC: return 12'd2;  4'hD: return 12'd4;  4'hE: return 12'd3;  default: return 12'd4;
    endcase
  endfunction

  function automatic logic [1:0] exp_low2(input logic [3:0] be);
    case (be)
      4'h2, 4'h6, 4'hA, 4'hE: return 2'd1;
      4'h4, 4'hC:             return 2'd2;
      4'h8:                   return 2'd3;
      default:                return 2'd0;
    endcase
  endfunction

  task automatic build(input logic wd, input logic [2:0] tc, input logic td, input logic ep,
                       input logic [1:0] attr, input logic [9:0] len, input logic [15:0] rid,
                       input logic [7:0] tag, input logic [3:0] be, input logic [13:0] addr,
                       input logic [15:0] cid, input logic [31:0] word,
                       output logic [72:0] b0, output logic [72:0] b1);
    logic [31:0] d0, d1, d2, sw;
    d0 = {1'b0, (wd ? 2'b10 : 2'b00), 5'b01010, 1'b0, tc, 4'b0, td, ep, attr, 2'b00, len};
    d1 = {cid, 4'b0000, exp_bc(be)};
    d2 = {rid, tag, 1'b0, addr[6:2], exp_low2(be)};
    sw = {word[7:0], word[15:8], word[23:16], word[31:24]};
    b0 = {d1, d0, 8'hFF, 1'b0};
    b1 = wd ? {sw, d2, 8'hFF, 1'b1} : {32'd0, d2, 8'h0F, 1'b1};
  endtask

  // Called just after a rising edge while the DUT is idle.
  task automatic issue(input logic wd, input logic [2:0] tc, input logic td, input logic ep,
                       input logic [1:0] attr, input logic [9:0] len, input logic [15:0] rid,
                       input logic [7:0] tag, input logic [3:0] be, input logic [13:0] addr,
                       input logic [1:0] bar);
    req_compl_wd = wd; req_tc = tc; req_td = td; req_ep = ep; req_attr = attr;
    req_len = len; req_rid = rid; req_tag = tag; req_be = be; req_addr = addr; req_bar = bar;
    req_compl = 1'b1;
    @(posedge clk); #1;
    req_compl = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!compl_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: busy still 1 after 50 cycles, required 0", name);
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every handshake pops one expected beat; compl_done must follow the last beat.
  always @(negedge clk) begin
    if (!sys_rst_n) begin
      hs_last_prev = 1'b0;
    end else begin
      if (compl_done || hs_last_prev)
        check("compl_done_timing", compl_done, hs_last_prev);
      if (compl_done) done_seen++;
      if (tvalid && tready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h with empty queue", {tdata, tkeep, tlast});
        end else begin
          check("beat", {tdata, tkeep, tlast}, exp_q.pop_front());
        end
      end
      hs_last_prev = tvalid && tready && tlast;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [72:0] b0, b1;
    int h0, d0c;

    sys_rst_n = 1'b0; tready = 1'b1; req_compl = 1'b0; req_compl_wd = 1'b0;
    req_tc = '0; req_td = 1'b0; req_ep = 1'b0; req_attr = '0; req_len = '0;
    req_rid = '0; req_tag = '0; req_be = '0; req_addr = '0; req_bar = '0;
    completer_id = 16'h0200; mem_addr = '0; mem_word = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_axis", {tvalid, tlast, tkeep, tdata}, 73'd0);
    check("rst_status", {compl_done, compl_busy, dbg_state}, 73'd0);
    check("rst_rd", {rd_addr, rd_be}, 73'd0);
    check("rst_tuser", tuser, 73'd0);
    @(posedge clk); #1;
    sys_rst_n = 1'b1;
    @(posedge clk); #1;

    // CplD with tready=1, hand-computed beats
    mem_addr = 14'h1002; mem_word = 32'h0A0015C7;
    exp_q.push_back({64'h02000004_4A000001, 8'hFF, 1'b0});
    exp_q.push_back({64'hC715000A_01000508, 8'hFF, 1'b1});
    exp_done++;
    issue(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0100, 8'h05, 4'hF, 14'h0008, 2'b01);
    @(negedge clk);
    check("cpld_rd_addr", rd_addr, 73'h1002);
    check("cpld_rd_be", rd_be, 73'hF);
    check("cpld_busy", compl_busy, 73'd1);
    wait_idle("cpld_idle");

    // Cpl without data, be=0000
    exp_q.push_back({64'h02000001_0A502003, 8'hFF, 1'b0});
    exp_q.push_back({64'h00000000_ABCD7E34, 8'h0F, 1'b1});
    exp_done++;
    issue(1'b0, 3'b101, 1'b0, 1'b0, 2'b10, 10'd3, 16'hABCD, 8'h7E, 4'h0, 14'h0034, 2'b00);
    wait_idle("cpl_idle");

    // Backpressure: 5 stalled cycles in BEAT0, 3 in BEAT1
    mem_addr = {2'b10, 12'h2AF}; mem_word = 32'hCAFEF00D;
    build(1'b1, 3'b010, 1'b1, 1'b0, 2'b01, 10'd1, 16'h1234, 8'h9A, 4'b0110, 14'h0ABC,
          16'h0200, 32'hCAFEF00D, b0, b1);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_done++;
    h0 = hs_count; d0c = done_seen;
    tready = 1'b0;
    issue(1'b1, 3'b010, 1'b1, 1'b0, 2'b01, 10'd1, 16'h1234, 8'h9A, 4'b0110, 14'h0ABC, 2'b10);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_beat0_hold", {tdata, tkeep, tlast}, b0);
      @(posedge clk); #1;
    end
    tready = 1'b1;
    @(posedge clk); #1;
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_beat1_hold", {tdata, tkeep, tlast}, b1);
      @(posedge clk); #1;
    end
    tready = 1'b1;
    wait_idle("bp_idle");
    check("bp_handshakes", hs_count - h0, 73'd2);
    check("bp_done_count", done_seen - d0c, 73'd1);

    // Byte-enable sweep
    for (int i = 0; i < 16; i++) begin
      logic [13:0] a;
      logic [3:0] be;
      be = i[3:0];
      a = 14'h0040 + 14'(i * 12);
      mem_addr = {2'b11, a[13:2]}; mem_word = 32'h11223344 + 32'(i);
      build(i[0], 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0042, i[7:0], be, a,
            16'h0200, mem_word, b0, b1);
      exp_q.push_back(b0); exp_q.push_back(b1); exp_done++;
      issue(i[0], 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0042, i[7:0], be, a, 2'b11);
      wait_idle("sweep_idle");
    end

    // Second request while in BEAT0 is ignored
    mem_addr = {2'b00, 12'h010}; mem_word = 32'h55AA1234;
    build(1'b1, 3'd1, 1'b0, 1'b1, 2'd0, 10'd1, 16'h0F0F, 8'h33, 4'b1100, 14'h0040,
          16'h0200, 32'h55AA1234, b0, b1);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_done++;
    h0 = hs_count;
    tready = 1'b0;
    issue(1'b1, 3'd1, 1'b0, 1'b1, 2'd0, 10'd1, 16'h0F0F, 8'h33, 4'b1100, 14'h0040, 2'b00);
    @(posedge clk); #1;
    issue(1'b0, 3'd7, 1'b1, 1'b0, 2'd3, 10'd5, 16'hFFFF, 8'hEE, 4'b0001, 14'h3FFC, 2'b11);
    @(negedge clk);
    check("dup_busy", compl_busy, 73'd1);
    check("dup_state_beat0", dbg_state, 73'd2);
    @(posedge clk); #1;
    tready = 1'b1;
    wait_idle("dup_idle");
    repeat (3) begin
      @(negedge clk);
      check("dup_stays_idle", compl_busy, 73'd0);
    end
    check("dup_handshakes", hs_count - h0, 73'd2);
    @(posedge clk); #1;

    // Reset asserted in BEAT1 under backpressure
    mem_addr = {2'b01, 12'h020}; mem_word = 32'h01020304;
    build(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0001, 8'h01, 4'hF, 14'h0080,
          16'h0200, 32'h01020304, b0, b1);
    exp_q.push_back(b0); exp_q.push_back(b1);
    d0c = done_seen;
    issue(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0001, 8'h01, 4'hF, 14'h0080, 2'b01);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tready = 1'b0;
    @(negedge clk);
    check("abort_in_beat1", {tvalid, tlast}, 73'b11);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("abort_axis_zero", {tvalid, tlast, tkeep, tdata}, 73'd0);
    check("abort_status_zero", {compl_done, compl_busy, rd_addr, rd_be}, 73'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(posedge clk); #1;
    @(posedge clk); #1;
    sys_rst_n = 1'b1;
    tready = 1'b1;
    @(posedge clk); #1;
    check("abort_no_done", done_seen - d0c, 73'd0);

    mem_addr = {2'b10, 12'h100}; mem_word = 32'hA5A5_0F0F;
    build(1'b1, 3'd2, 1'b0, 1'b0, 2'd1, 10'd1, 16'h0777, 8'h44, 4'b0011, 14'h0400,
          16'h0200, 32'hA5A5_0F0F, b0, b1);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_done++;
    issue(1'b1, 3'd2, 1'b0, 1'b0, 2'd1, 10'd1, 16'h0777, 8'h44, 4'b0011, 14'h0400, 2'b10);
    wait_idle("post_reset_idle");
    repeat (2) @(posedge clk);
    #1;

    check("queue_drained", exp_q.size(), 73'd0);
    check("done_total", done_seen, exp_done);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_tx_cpl_engine.md
PIO_TX_CPL_ENGINE -- requirements
Module: pio_tx_cpl_engine

Interface
REQ-001 SHALL have parameter TCQ, default 1, meaning simulation clock-to-out delay applied to all registered assignments.
REQ-002 SHALL have port clk, input, 1, the single block clock.
REQ-003 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_compl, input, 1, completion request strobe; sampled only in IDLE.
REQ-005 SHALL have port req_compl_wd, input, 1, selects completion type: 1 = CplD (with data), 0 = Cpl (no data).
REQ-006 SHALL have request-attribute ports, all inputs:
- req_tc, 3 bits.
- req_td, 1 bit.
- req_ep, 1 bit.
- req_attr, 2 bits.
- req_len, 10 bits.
- req_rid, 16 bits.
- req_tag, 8 bits.
- req_be, 4 bits (first-DW byte enables).
- req_addr, 14 bits (byte address).
- req_bar, 2 bits (BAR select).
REQ-007 SHALL have port completer_id, input, 16, bus/dev/func placed in completion DW1.
REQ-008 SHALL have ports rd_addr (output, 14), rd_be (output, 4) and rd_data (input, 32): the read port of the PIO register/BIOS space; rd_data is valid one clk after rd_addr.
REQ-009 SHALL have AXI-Stream TX master ports:
- s_axis_tx_tdata, output, 64.
- s_axis_tx_tkeep, output, 8.
- s_axis_tx_tlast, output, 1.
- s_axis_tx_tvalid, output, 1.
- s_axis_tx_tready, input, 1.
- s_axis_tx_tuser, output, 4.
REQ-010 SHALL have ports compl_done (output, 1, one-cycle pulse) and compl_busy (output, 1, high whenever state is not IDLE).

Function
REQ-011 SHALL implement states IDLE, RD_WAIT, BEAT0, BEAT1.
- IDLE to RD_WAIT: on req_compl=1.
- RD_WAIT to BEAT0: unconditionally after one cycle.
- BEAT0 to BEAT1: on tvalid&tready.
- BEAT1 to IDLE: on tvalid&tready.
REQ-012 SHALL, in IDLE with req_compl=1, capture all req_* fields into internal registers; req_compl asserted while not IDLE SHALL be ignored.
REQ-013 SHALL drive rd_addr={captured req_bar, captured req_addr[13:2]} and rd_be=captured req_be, held from RD_WAIT until return to IDLE.
REQ-014 SHALL register rd_data at the end of RD_WAIT and keep it stable through BEAT1.
REQ-015 SHALL build completion DW0 as {0, fmt, 5'b01010, 0, tc, 4'b0, td, ep, attr, 2'b00, len}.
- fmt = 2'b10 for CplD.
- fmt = 2'b00 for Cpl.
REQ-016 SHALL build DW1 as {completer_id, 3'b000 status, 0 BCM, byte_count[11:0]}.
REQ-017 SHALL build DW2 as {rid, tag, 0, lower_addr[6:0]}.
REQ-018 SHALL compute byte_count from req_be:
- 1xx1 gives 4.
- 01x1 or 1x10 gives 3.
- 0011, 0110 or 1100 gives 2.
- Any single-bit pattern or 0000 gives 1.
REQ-019 SHALL compute lower_addr as {req_addr[6:2], low2}, where low2 is the index of the lowest set bit of req_be, or 00 when req_be=0000.
REQ-020 SHALL drive BEAT0 as tdata={DW1,DW0}, tkeep=8'hFF, tlast=0.
REQ-021 SHALL drive BEAT1 as follows:
- CplD: tdata={byteswap(rd_data),DW2}, tkeep=8'hFF, tlast=1.
- Cpl: tdata={32'h0,DW2}, tkeep=8'h0F, tlast=1.
- byteswap(x) = {x[7:0],x[15:8],x[23:16],x[31:24]}.
REQ-022 SHALL hold tvalid=1 in BEAT0/BEAT1 and keep tdata/tkeep/tlast stable while tready=0; no combinational path from tready to tdata.
REQ-023 SHALL pulse compl_done exactly one cycle, in the cycle after the BEAT1 handshake.
REQ-024 SHALL drive s_axis_tx_tuser=4'b0000 always.
REQ-025 SHALL treat req_len as pass-through; only single-DW payload is generated regardless of req_len.

Reset
REQ-026 SHALL on sys_rst_n=0, asynchronously and regardless of state:
- enter IDLE.
- drive tvalid=0, tlast=0, tdata=0, tkeep=0, compl_done=0, compl_busy=0, rd_addr=0, rd_be=0.
REQ-027 SHALL NOT emit compl_done for a completion aborted by reset; the next request after reset release SHALL start cleanly from IDLE.

Structure
REQ-028 SHALL place in shared package pio_pkg:
- fmt constants.
- Cpl type constant 5'b01010.
- State encoding typedef.
- tkeep constants.
REQ-029 SHALL isolate byte_count/lower_addr logic in combinational sub-module pio_cpl_bc_calc (inputs be[3:0], addr[6:0]; outputs byte_count[11:0], lower_addr[6:0]).

Verification
REQ-030 SHALL cover CplD with tready=1: req_be=1111, req_addr=0x0008, req_bar=01, rid=0x0100, tag=0x05, rd_data=0x0A0015C7.
- Required: rd_addr=0x1002.
- Required: beat0 DW0=0x4A000001, byte_count=4.
- Required: beat1={0xC715000A, 0x01000508}, tlast=1.
- Required: compl_done one cycle later.
REQ-031 SHALL cover Cpl (req_compl_wd=0) with req_be=0000.
- Required: fmt=00, byte_count=1, lower_addr=addr[6:2]<<2.
- Required: beat1 tkeep=0x0F.
REQ-032 SHALL cover backpressure: tready=0 for 5 cycles in BEAT0 and 3 cycles in BEAT1 -> tdata/tkeep/tlast stable; exactly two handshakes; one compl_done.
REQ-033 SHALL cover byte-enable table: sweep all 16 req_be values -> byte_count and lower_addr[1:0] match REQ-018/REQ-019 (e.g. be=0110 -> 2, low2=01).
REQ-034 SHALL cover a second req_compl during BEAT0 -> ignored; exactly one TLP; compl_busy high until IDLE.
REQ-035 SHALL cover sys_rst_n=0 asserted in BEAT1 with tready=0 -> tvalid=0 immediately, no compl_done; a new request after release completes normally.
